// File: rtl/fir_mac_serial.sv
// rtl/fir_mac_serial.sv - time-multiplexed FIR filter with one shared multiplier-accumulator; define FIR_SAT_EN to saturate results, leave it undefined to wrap
module fir_mac_serial #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int FRAC   = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic                      out_valid,
  output logic signed [DATA_W-1:0]  out_data,
  output logic                      sat_flag
);

  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  // Headroom of clog2(TAPS) bits keeps the full-precision sum from overflowing.
  localparam int ACC_W  = DATA_W + COEF_W + AW;

  localparam logic [AW-1:0]          K_LAST = AW'(TAPS - 1);
  localparam logic [AW:0]            TAPS_L = (AW + 1)'(TAPS);
  localparam logic signed [ACC_W:0]  RND    = (ACC_W + 1)'(1) << (FRAC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] dline [TAPS];
  logic signed [COEF_W-1:0] coef  [TAPS];
  logic [AW-1:0]            wp;
  logic [AW-1:0]            rd;
  logic [AW-1:0]            k;
  logic signed [ACC_W-1:0]  acc;

  logic signed [PROD_W-1:0] d_ext;
  logic signed [PROD_W-1:0] c_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W:0]    rnd;
  logic signed [DATA_W-1:0] res;
  logic                     clip;
  logic [AW-1:0]            wp_next;
  logic [AW-1:0]            rd_prev;
  logic                     coef_hit;

  // Circular pointer arithmetic that also works when TAPS is not a power of two.
  assign wp_next  = (wp == K_LAST) ? '0 : wp + 1'b1;
  assign rd_prev  = (rd == '0) ? K_LAST : rd - 1'b1;
  assign coef_hit = coef_we && ({1'b0, coef_addr} < TAPS_L);

  // Shared MAC: rd walks backwards from the newest sample while k walks the coefficients.
  assign d_ext   = PROD_W'(dline[rd]);
  assign c_ext   = PROD_W'(coef[k]);
  assign prod    = d_ext * c_ext;
  assign acc_sum = acc + ACC_W'(prod);

  // Round half up one bit wider than the accumulator so the offset cannot overflow.
  assign rnd = (ACC_W + 1)'(acc_sum) + RND;

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W:0] MAX_V = (ACC_W + 1)'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

  logic signed [ACC_W:0] shifted;
  assign shifted = rnd >>> FRAC;

  // Clamp the scaled sum to the signed output range and flag the clip.
  always_comb begin
    res  = shifted[DATA_W-1:0];
    clip = 1'b0;
    if (shifted > MAX_V) begin
      res  = MAX_V[DATA_W-1:0];
      clip = 1'b1;
    end else if (shifted < MIN_V) begin
      res  = MIN_V[DATA_W-1:0];
      clip = 1'b1;
    end
  end
`else
  assign res  = DATA_W'(rnd >>> FRAC);
  assign clip = 1'b0;
`endif

  // Control FSM with registered handshake/result outputs, delay line and coefficient store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
      wp        <= '0;
      rd        <= '0;
      k         <= '0;
      acc       <= '0;
      for (int i = 0; i < TAPS; i++) begin
        dline[i] <= '0;
        coef[i]  <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          // A coefficient written in the accept cycle is already visible to the first MAC cycle.
          if (coef_hit) begin
            coef[coef_addr] <= coef_data;
          end
          if (in_valid) begin
            dline[wp] <= in_data;
            rd        <= wp;
            wp        <= wp_next;
            k         <= '0;
            acc       <= '0;
            in_ready  <= 1'b0;
            state     <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc_sum;
          k   <= k + 1'b1;
          rd  <= rd_prev;
          // The last product is folded in combinationally so the result lands one cycle earlier.
          if (k == K_LAST) begin
            out_data  <= res;
            sat_flag  <= clip;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_serial.sv
// tb/tb_fir_mac_serial.sv - scoreboard bench for fir_mac_serial against a software FIR model
module tb_fir_mac_serial;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int TAPS   = 8;
  localparam int FRAC   = 15;
  localparam int AW     = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              sat_flag;

  fir_mac_serial #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .TAPS  (TAPS),
    .FRAC  (FRAC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        sat;
    int          acc_cyc;
  } exp_t;

  exp_t   sb[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     last_out = -1;
  bit     chk_spacing = 1'b0;
  longint hist[TAPS];
  longint cmodel[TAPS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < TAPS; i++) begin
      hist[i]   = 0;
      cmodel[i] = 0;
    end
  endtask

  task automatic model_accept(input logic signed [15:0] x, input int ac, input bit push);
    longint y;
    longint r;
    exp_t   e;
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    y = 0;
    for (int i = 0; i < TAPS; i++) y += cmodel[i] * hist[i];
    r = (y + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
`ifdef FIR_SAT_EN
    if (r > 32767) begin
      e.data = 16'h7FFF;
      e.sat  = 1'b1;
    end else if (r < -32768) begin
      e.data = 16'h8000;
      e.sat  = 1'b1;
    end else begin
      e.data = r[15:0];
      e.sat  = 1'b0;
    end
`else
    e.data = r[15:0];
    e.sat  = 1'b0;
`endif
    e.acc_cyc = ac;
    if (push) sb.push_back(e);
  endtask

  task automatic wait_ready();
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_timeout", in_ready, 1);
  endtask

  task automatic send(input logic [15:0] x, input bit hold, input bit push);
    wait_ready();
    if (!in_ready) return;
    in_valid = 1'b1;
    in_data  = x;
    model_accept($signed(x), cyc, push);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic write_coef(input int a, input logic [15:0] d);
    wait_ready();
    coef_we   = 1'b1;
    coef_addr = a[AW-1:0];
    coef_data = d;
    cmodel[a] = $signed(d);
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_sat_flag"}, sat_flag, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("sat_flag", sat_flag, e.sat);
        chk("latency", cyc - e.acc_cyc, TAPS + 1);
        if (chk_spacing && last_out >= 0) chk("spacing", cyc - last_out, TAPS + 2);
      end
      last_out = cyc;
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_state("reset");

    // Impulse response with every tap at 0.5: rounding yields exactly 0x4000.
    for (int i = 0; i < TAPS; i++) write_coef(i, 16'h4000);
    last_out    = -1;
    chk_spacing = 1'b1;
    send(16'h7FFF, 1'b0, 1'b1);
    for (int i = 0; i < TAPS; i++) send(16'h0000, 1'b0, 1'b1);
    drain();
    chk_spacing = 1'b0;

    // Single-tap pass-through plus in_ready busy window.
    write_coef(0, 16'h7FFF);
    for (int i = 1; i < TAPS; i++) write_coef(i, 16'h0000);
    send(16'h1000, 1'b0, 1'b1);
    @(negedge clk);
    chk("busy_first", in_ready, 0);
    repeat (TAPS) @(negedge clk);
    chk("busy_last", in_ready, 0);
    @(negedge clk);
    chk("ready_again", in_ready, 1);
    drain();

    // Full-scale positive then negative runs: saturation or wrap, in_valid held across busy.
    for (int i = 0; i < TAPS; i++) write_coef(i, 16'h7FFF);
    for (int i = 0; i < TAPS; i++) send(16'h7FFF, 1'b0, 1'b1);
    for (int i = 0; i < TAPS; i++) send(16'h8000, 1'b1, 1'b1);
    in_valid = 1'b0;
    drain();

    // Ramp coefficients and up-count input across several write-pointer wraps.
    for (int i = 0; i < TAPS; i++) write_coef(i, 16'(i + 1));
    for (int i = 1; i <= 20; i++) send(16'(i), 1'b0, 1'b1);
    drain();

    // Coefficient write issued mid-MAC must be dropped.
    send(16'h2000, 1'b0, 1'b1);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = '0;
    coef_data = 16'h7FFF;
    @(posedge clk);
    #1 coef_we = 1'b0;
    send(16'h0100, 1'b0, 1'b1);
    drain();

    // Reset during MAC cycle 4 aborts the sample and clears history and coefficients.
    send(16'h3000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    check_reset_state("midmac");
    repeat (20) @(negedge clk);
    send(16'h7FFF, 1'b0, 1'b1);
    drain();
    for (int i = 0; i < TAPS; i++) write_coef(i, 16'(16'h0800 * (i + 1)));
    send(16'h4000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send(16'h0000, 1'b0, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
